// File: rtl/trapezoid_feeder.sv
// Host-side feeder for the trapezoid rasterizer: accepts a descriptor,
// streams its four vertices on nt/xi/yi, counts po pixels, reports done.
module trapezoid_feeder #(
    parameter int TIMEOUT = 65535,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic [7:0]       desc_xul,
    input  logic [7:0]       desc_xur,
    input  logic [7:0]       desc_yu,
    input  logic [7:0]       desc_xdl,
    input  logic [7:0]       desc_xdr,
    input  logic [7:0]       desc_yd,
    output logic             nt,
    output logic [7:0]       xi,
    output logic [7:0]       yi,
    input  logic             busy,
    input  logic             po,
    output logic             done,
    output logic [CNT_W-1:0] pix_cnt,
    output logic             err,
    output logic             timeout
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] PIX_MAX = '1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        V0,
        V1,
        V2,
        V3,
        WAIT,
        FIN
    } state_t;

    typedef struct packed {
        logic [7:0] xul;
        logic [7:0] xur;
        logic [7:0] yu;
        logic [7:0] xdl;
        logic [7:0] xdr;
        logic [7:0] yd;
    } desc_t;

    state_t           state, state_d;
    desc_t            dsc_q, dsc_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             seen_q, seen_d;
    logic             nt_d, done_d, err_d, timeout_d, ready_d;
    logic [7:0]       xi_d, yi_d;
    logic [CNT_W-1:0] pix_d;
    logic             accept, geom_ok;

    assign accept  = desc_valid && !busy;
    assign geom_ok = ($signed(desc_xul) <= $signed(desc_xur))
                  && ($signed(desc_xdl) <= $signed(desc_xdr))
                  && ($signed(desc_yd)  <= $signed(desc_yu));

    // Output registers are loaded with the value belonging to the next state,
    // so each vertex appears on the bus for the whole cycle of its state.
    always_comb begin
        state_d   = state;
        dsc_d     = dsc_q;
        wcnt_d    = wcnt_q;
        seen_d    = seen_q;
        nt_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = err;
        timeout_d = timeout;
        ready_d   = desc_ready;
        xi_d      = xi;
        yi_d      = yi;
        pix_d     = pix_cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    dsc_d     = '{desc_xul, desc_xur, desc_yu,
                                  desc_xdl, desc_xdr, desc_yd};
                    pix_d     = '0;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    seen_d    = 1'b0;
                    ready_d   = 1'b0;
                    if (geom_ok) begin
                        state_d = V0;
                        nt_d    = 1'b1;
                        xi_d    = desc_xul;
                        yi_d    = desc_yu;
                    end else begin
                        state_d = FIN;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            V0: begin
                state_d = V1;
                xi_d    = dsc_q.xur;
                yi_d    = dsc_q.yu;
            end
            V1: begin
                state_d = V2;
                xi_d    = dsc_q.xdl;
                yi_d    = dsc_q.yd;
            end
            V2: begin
                state_d = V3;
                xi_d    = dsc_q.xdr;
                yi_d    = dsc_q.yd;
            end
            V3: begin
                state_d = WAIT;
                wcnt_d  = '0;
            end
            WAIT: begin
                if (po && pix_cnt != PIX_MAX) begin
                    pix_d = pix_cnt + 1'b1;
                end
                if (busy) begin
                    seen_d = 1'b1;
                end
                if (!busy && seen_q) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else if (wcnt_q == WC_LAST) begin
                    state_d   = FIN;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dsc_q      <= '0;
            wcnt_q     <= '0;
            seen_q     <= 1'b0;
            nt         <= 1'b0;
            xi         <= '0;
            yi         <= '0;
            done       <= 1'b0;
            pix_cnt    <= '0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            desc_ready <= 1'b1;
        end else begin
            state      <= state_d;
            dsc_q      <= dsc_d;
            wcnt_q     <= wcnt_d;
            seen_q     <= seen_d;
            nt         <= nt_d;
            xi         <= xi_d;
            yi         <= yi_d;
            done       <= done_d;
            pix_cnt    <= pix_d;
            err        <= err_d;
            timeout    <= timeout_d;
            desc_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_trapezoid_feeder.sv
// Bench for trapezoid_feeder: a behavioural rasterizer model drives busy/po
// from the geometry and the feeder's outputs are checked cycle by cycle.
module tb_trapezoid_feeder;

    localparam int TO = 20;
    localparam int CW = 4;
    localparam int PMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          desc_valid;
    logic          desc_ready;
    logic [7:0]    desc_xul, desc_xur, desc_yu;
    logic [7:0]    desc_xdl, desc_xdr, desc_yd;
    logic          nt;
    logic [7:0]    xi, yi;
    logic          busy, po;
    logic          done;
    logic [CW-1:0] pix_cnt;
    logic          err, timeout;

    int compared   = 0;
    int mismatched = 0;

    trapezoid_feeder #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_xul   (desc_xul),
        .desc_xur   (desc_xur),
        .desc_yu    (desc_yu),
        .desc_xdl   (desc_xdl),
        .desc_xdr   (desc_xdr),
        .desc_yd    (desc_yd),
        .nt         (nt),
        .xi         (xi),
        .yi         (yi),
        .busy       (busy),
        .po         (po),
        .done       (done),
        .pix_cnt    (pix_cnt),
        .err        (err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Pixels covered by the trapezoid, edges interpolated row by row.
    function automatic int pix_count(input int xul, xur, yu, xdl, xdr, yd);
        int n;
        int h;
        n = 0;
        h = yu - yd;
        for (int y = yd; y <= yu; y++) begin
            int xl;
            int xr;
            if (h == 0) begin
                xl = (xul < xdl) ? xul : xdl;
                xr = (xur > xdr) ? xur : xdr;
            end else begin
                xl = xdl + ((xul - xdl) * (y - yd)) / h;
                xr = xdr + ((xur - xdr) * (y - yd)) / h;
            end
            if (xr >= xl) n += xr - xl + 1;
        end
        return n;
    endfunction

    // Starts and ends just after a falling edge; returns after the accept edge.
    task automatic drive_desc(input int a, b, c, d, e, f);
        desc_xul   = 8'(a);
        desc_xur   = 8'(b);
        desc_yu    = 8'(c);
        desc_xdl   = 8'(d);
        desc_xdr   = 8'(e);
        desc_yd    = 8'(f);
        desc_valid = 1'b1;
        compared++;
        if (desc_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL desc_ready_idle: got %b want 1", desc_ready);
        end
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    task automatic check_vertices(input int a, b, c, d, e, f);
        compared++;
        if ({nt, xi, yi} !== {1'b1, 8'(a), 8'(c)}) begin
            mismatched++;
            $display("FAIL vtx0: got nt=%b xi=%h yi=%h want 1 %h %h",
                     nt, xi, yi, 8'(a), 8'(c));
        end
        @(negedge clk);
        compared++;
        if ({nt, xi, yi} !== {1'b0, 8'(b), 8'(c)}) begin
            mismatched++;
            $display("FAIL vtx1: got nt=%b xi=%h yi=%h want 0 %h %h",
                     nt, xi, yi, 8'(b), 8'(c));
        end
        @(negedge clk);
        compared++;
        if ({nt, xi, yi} !== {1'b0, 8'(d), 8'(f)}) begin
            mismatched++;
            $display("FAIL vtx2: got nt=%b xi=%h yi=%h want 0 %h %h",
                     nt, xi, yi, 8'(d), 8'(f));
        end
        @(negedge clk);
        compared++;
        if ({nt, xi, yi} !== {1'b0, 8'(e), 8'(f)}) begin
            mismatched++;
            $display("FAIL vtx3: got nt=%b xi=%h yi=%h want 0 %h %h",
                     nt, xi, yi, 8'(e), 8'(f));
        end
    endtask

    // Rasterizer model: busy for max(n,1) cycles emitting n pixels; with
    // fall set, the last pixel comes together with busy dropping.
    task automatic finish_run(input int n, input bit fall, input int xdr);
        int m;
        int exp_n;
        bit got;
        m     = (n < 1) ? 1 : n;
        exp_n = (n > PMAX) ? PMAX : n;
        got   = 1'b0;
        busy  = 1'b1;
        po    = 1'b0;
        for (int j = 1; j <= m; j++) begin
            @(negedge clk);
            po   = (j <= n);
            busy = !(fall && j == m);
        end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            busy = 1'b0;
            po   = 1'b0;
            if (done === 1'b1) got = 1'b1;
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL done_wait: got no done want done pulse");
        end else begin
            compared++;
            if ({pix_cnt, err, timeout, xi} !==
                {CW'(exp_n), 1'b0, 1'b0, 8'(xdr)}) begin
                mismatched++;
                $display("FAIL result: got cnt=%0d err=%b to=%b xi=%h want %0d 0 0 %h",
                         pix_cnt, err, timeout, xi, exp_n, 8'(xdr));
            end
        end
        @(negedge clk);
        compared++;
        if ({done, desc_ready, pix_cnt} !== {1'b0, 1'b1, CW'(exp_n)}) begin
            mismatched++;
            $display("FAIL after_done: got done=%b rdy=%b cnt=%0d want 0 1 %0d",
                     done, desc_ready, pix_cnt, exp_n);
        end
    endtask

    task automatic run_valid(input int a, b, c, d, e, f, input bit fall);
        int n;
        n = pix_count(a, b, c, d, e, f);
        drive_desc(a, b, c, d, e, f);
        check_vertices(a, b, c, d, e, f);
        finish_run(n, fall && n >= 2, e);
    endtask

    task automatic run_invalid(input int a, b, c, d, e, f);
        drive_desc(a, b, c, d, e, f);
        compared++;
        if ({nt, done, err, timeout, pix_cnt} !== {4'b0110, CW'(0)}) begin
            mismatched++;
            $display("FAIL invalid: got nt=%b done=%b err=%b to=%b cnt=%0d want 0 1 1 0 0",
                     nt, done, err, timeout, pix_cnt);
        end
        @(negedge clk);
        compared++;
        if ({done, desc_ready, nt, err} !== 4'b0101) begin
            mismatched++;
            $display("FAIL invalid_after: got done=%b rdy=%b nt=%b err=%b want 0 1 0 1",
                     done, desc_ready, nt, err);
        end
    endtask

    task automatic test_reset();
        int pulses;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compared++;
        if ({nt, xi, yi, done, pix_cnt, err, timeout, desc_ready} !==
            {1'b0, 8'h00, 8'h00, 1'b0, CW'(0), 3'b001}) begin
            mismatched++;
            $display("FAIL reset_state: got nt=%b xi=%h yi=%h done=%b cnt=%0d err=%b to=%b rdy=%b",
                     nt, xi, yi, done, pix_cnt, err, timeout, desc_ready);
        end
        drive_desc(-2, 1, 1, -2, 1, -1);
        check_vertices(-2, 1, 1, -2, 1, -1);
        busy = 1'b1;
        po   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        busy  = 1'b0;
        po    = 1'b0;
        compared++;
        if ({nt, done, pix_cnt, desc_ready} !== {1'b0, 1'b0, CW'(0), 1'b1}) begin
            mismatched++;
            $display("FAIL reset_midrun: got nt=%b done=%b cnt=%0d rdy=%b want 0 0 0 1",
                     nt, done, pix_cnt, desc_ready);
        end
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        compared++;
        if (pulses != 0) begin
            mismatched++;
            $display("FAIL reset_no_done: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_rectangle();
        run_valid(-2, 1, 1, -2, 1, -1, 1'b0);
    endtask

    task automatic test_point();
        run_valid(5, 5, 3, 5, 5, 3, 1'b0);
    endtask

    task automatic test_invalid();
        run_invalid(4, 2, 3, 0, 1, 0);
        run_invalid(0, 1, -1, 0, 1, 2);
    endtask

    task automatic test_timeout();
        int hit;
        hit = 0;
        drive_desc(0, 1, 0, 0, 1, 0);
        check_vertices(0, 1, 0, 0, 1, 0);
        busy = 1'b1;
        for (int i = 1; i <= 40 && hit == 0; i++) begin
            @(negedge clk);
            if (done === 1'b1) hit = i;
        end
        // hit counts falling edges from the last vertex cycle; WAIT starts one later
        compared++;
        if (hit - 1 != TO) begin
            mismatched++;
            $display("FAIL timeout_latency: got %0d want %0d", hit - 1, TO);
        end
        compared++;
        if ({timeout, err, pix_cnt} !== {2'b10, CW'(0)}) begin
            mismatched++;
            $display("FAIL timeout_flags: got to=%b err=%b cnt=%0d want 1 0 0",
                     timeout, err, pix_cnt);
        end
        busy = 1'b0;
        @(negedge clk);
        compared++;
        if ({done, timeout} !== 2'b01) begin
            mismatched++;
            $display("FAIL timeout_hold: got done=%b to=%b want 0 1", done, timeout);
        end
    endtask

    task automatic test_busy_hold();
        desc_xul   = 8'(1);
        desc_xur   = 8'(3);
        desc_yu    = 8'(2);
        desc_xdl   = 8'(0);
        desc_xdr   = 8'(4);
        desc_yd    = 8'(-1);
        desc_valid = 1'b1;
        busy       = 1'b1;
        repeat (3) begin
            @(negedge clk);
            compared++;
            if ({desc_ready, nt, done} !== 3'b100) begin
                mismatched++;
                $display("FAIL busy_hold: got rdy=%b nt=%b done=%b want 1 0 0",
                         desc_ready, nt, done);
            end
        end
        busy = 1'b0;
        @(negedge clk);
        desc_valid = 1'b0;
        check_vertices(1, 3, 2, 0, 4, -1);
        finish_run(pix_count(1, 3, 2, 0, 4, -1), 1'b0, 4);
    endtask

    task automatic test_saturate();
        run_valid(0, 5, 2, 0, 5, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_invalid(3, 1, 0, 0, 0, 0);
        run_valid(-1, 1, 0, -1, 1, 0, 1'b1);
        run_invalid(0, 0, 0, 2, 1, 0);
    endtask

    task automatic test_random();
        int yd, h, xdl, xul, wd, wu;
        for (int k = 0; k < 10; k++) begin
            yd  = int'($urandom_range(0, 5)) - 3;
            h   = int'($urandom_range(0, 2));
            xdl = int'($urandom_range(0, 7)) - 4;
            xul = int'($urandom_range(0, 7)) - 4;
            wd  = int'($urandom_range(0, 3));
            wu  = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                run_invalid(xul, xul - 1 - int'($urandom_range(0, 2)),
                            yd + h, xdl, xdl + wd, yd);
            end else begin
                run_valid(xul, xul + wu, yd + h, xdl, xdl + wd, yd,
                          1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        desc_valid = 1'b0;
        desc_xul   = '0;
        desc_xur   = '0;
        desc_yu    = '0;
        desc_xdl   = '0;
        desc_xdr   = '0;
        desc_yd    = '0;
        busy       = 1'b0;
        po         = 1'b0;
        test_reset();
        test_rectangle();
        test_point();
        test_invalid();
        test_timeout();
        test_busy_hold();
        test_saturate();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
